fifo_1ton_a1: RTL
=================

Name: fifo_1ton_A1

Overview:
- Single-clock, first-word-fall-through width-expanding FIFO. It packs NSIZE narrow write words of DSIZE bits into one wide word of NSIZE*DSIZE bits.
- It is the write-narrow/read-wide counterpart of the team's N-to-1 FIFO. It sits between a byte-serial source (e.g. I2C receive shifter) and a wide bus consumer.
- Packet boundaries are supported through wr_last: a partial group is padded with DEF_VALUE and flushed.

Parameters:
- DSIZE, 8, narrow (write) word width.
- NSIZE, 4, narrow words per wide word; legal values 1, 2, 4, 8, 16.
- DEPTH, 8, wide-word storage entries, excluding the output register; any value >= 2.
- ALMOST, 2, almost-full/almost-empty threshold in wide words.
- DEF_VALUE, 0, DSIZE-bit value used for reset contents and padded lanes.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe; accepted when wr_en && !wr_full.
- wr_data  in  DSIZE  narrow write word.
- wr_last  in  1  marks the accepted word as the last of a packet; forces a commit.
- wr_full  out  1  storage holds DEPTH wide words; all writes are dropped.
- wr_almost_full  out  1  mem_count >= DEPTH-ALMOST.
- wr_count  out  $clog2((DEPTH+1)*NSIZE)+1  narrow-word occupancy.
- rd_en  in  1  consume the presented wide word; ignored when !rd_vld.
- rd_data  out  DSIZE*NSIZE  head wide word (FWFT).
- rd_vld  out  1  rd_data is valid.
- rd_empty  out  1  equals !rd_vld.
- rd_last  out  1  head word was committed by wr_last; qualified by rd_vld.
- rd_almost_empty  out  1  rd_count <= ALMOST.
- rd_count  out  $clog2(DEPTH+1)+1  wide words held (memory plus output register).

Behaviour:

Reset (asynchronous, active-high):
- Clears lane_cnt, pointers, mem_count and the pack register.
- Clears all outputs: rd_vld=0, rd_empty=1, rd_last=0, rd_data={NSIZE{DEF_VALUE}}, all counts 0, all flags 0 except rd_empty and rd_almost_empty, which are 1.
- Reset mid-packet discards the partial group. The next write lands in lane 0.

Pack stage:
- lane_cnt runs 0..NSIZE-1.
- Accepted word k is placed at bits [DSIZE*(NSIZE-1-k) +: DSIZE], so the first-written word is the MSBs.
- Commit happens on the same edge as an accepted write with lane_cnt==NSIZE-1 or wr_last=1.
  - The committed wide word is the pack register merged with the incoming word.
  - Unwritten lanes are DEF_VALUE.
  - The last flag is stored with the entry.
  - lane_cnt returns to 0.
- NSIZE=1: every accepted write commits.

Storage:
- Circular buffer of DEPTH entries; wr_ptr and rd_ptr wrap from DEPTH-1 to 0.
- mem_count ranges 0..DEPTH and counts memory only.
- wr_full = (mem_count==DEPTH). It blocks every write, including lanes that would only enter the pack register.

Output register (FWFT):
- Loads the head entry when mem_count>0 and either (!rd_vld) or (rd_vld && rd_en).
- Latency: a word committed at edge T appears with rd_vld=1 after edge T+1 (when the output register is free).
- rd_en && rd_vld with mem_count==0: rd_vld drops to 0 at the next edge.
- Simultaneous commit and memory pop: mem_count is unchanged and ordering is preserved.
- Commit into an empty memory with the output register free: the word passes through memory and is loaded at the next edge; it is never bypassed.

Counts and flags:
- rd_count = mem_count + rd_vld.
- wr_count = rd_count*NSIZE + lane_cnt.
- Flags and counts are combinational from registered state only.

Total capacity is DEPTH+1 wide words.

Optional Feature:
- Macro: FIFO_1TON_KEEP_EN.
- Defined:
  - Adds output port rd_keep [NSIZE-1:0], stored per entry.
  - Bit NSIZE-1-k is 1 if lane k was written; full groups give all ones.
  - Resets to 0 and is qualified by rd_vld.
- Undefined:
  - No rd_keep port and no keep storage.
  - Padded lanes are distinguishable only by DEF_VALUE.

Test Plan:
1. DSIZE=8, NSIZE=4: write 0x11,0x22,0x33,0x44 on consecutive cycles, with the 4th write at edge T -> after edge T+1: rd_vld=1, rd_data=0x11223344, rd_last=0, rd_count=1; wr_count 1,2,3 then 4.
2. Write 0xAA, then 0xBB with wr_last=1 -> rd_data=0xAABB0000, rd_last=1; with FIFO_1TON_KEEP_EN, rd_keep=4'b1100. The next write lands in lane 0.
3. DEPTH=8, rd_en=0, write 36 words -> wr_full=1, rd_count=9, wr_count=36; wr_almost_full rose when mem_count reached 6. The 37th write is dropped and counts are unchanged.
4. With mem_count=3, commit and rd_en on the same edge -> mem_count stays 3, and subsequent reads return words in write order.
5. Assert rst after 2 accepted writes and while rd_vld=1 -> immediately rd_vld=0, rd_empty=1, counts 0. Then writing 0x01..0x04 yields 0x01020304.
6. rd_en held at 1, stream 160 narrow words (values 0..159) -> 40 wide words out in order, e.g. word 39 = 0x9C9D9E9F. Both pointers wrap at least 4 times; no loss or duplication.

Source files
------------

// File: rtl/fifo_1ton_a1.sv
// Width-expanding FWFT FIFO: packs NSIZE narrow writes into one wide word; wr_last flushes a partial group.
// Optional per-lane keep mask on the read side when FIFO_1TON_KEEP_EN is defined.
module fifo_1ton_a1 #(
  parameter int DSIZE  = 8,
  parameter int NSIZE  = 4,
  parameter int DEPTH  = 8,
  parameter int ALMOST = 2,
  parameter logic [DSIZE-1:0] DEF_VALUE = '0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   wr_en,
  input  logic [DSIZE-1:0]                       wr_data,
  input  logic                                   wr_last,
  output logic                                   wr_full,
  output logic                                   wr_almost_full,
  output logic [$clog2((DEPTH+1)*NSIZE):0]       wr_count,
  input  logic                                   rd_en,
  output logic [DSIZE*NSIZE-1:0]                 rd_data,
`ifdef FIFO_1TON_KEEP_EN
  output logic [NSIZE-1:0]                       rd_keep,
`endif
  output logic                                   rd_vld,
  output logic                                   rd_empty,
  output logic                                   rd_last,
  output logic                                   rd_almost_empty,
  output logic [$clog2(DEPTH+1):0]               rd_count
);

  localparam int DW  = DSIZE * NSIZE;
  localparam int LW  = (NSIZE > 1) ? $clog2(NSIZE) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int MCW = $clog2(DEPTH + 1);
  localparam int RCW = $clog2(DEPTH + 1) + 1;
  localparam int WCW = $clog2((DEPTH + 1) * NSIZE) + 1;
  localparam logic [DW-1:0]  DEF_WIDE = {NSIZE{DEF_VALUE}};
  localparam logic [LW-1:0]  LANE_MAX = LW'(NSIZE - 1);
  localparam logic [PW-1:0]  PTR_MAX  = PW'(DEPTH - 1);
  localparam logic [MCW-1:0] MEM_FULL = MCW'(DEPTH);

  logic [LW-1:0]  lane_q, lane_d;
  logic [DW-1:0]  pack_q, pack_d, merged;
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [MCW-1:0] mem_cnt_q, mem_cnt_d;
  logic [DW-1:0]  mem_data_q [DEPTH];
  logic           mem_last_q [DEPTH];
  logic [DW-1:0]  out_data_q;
  logic           out_vld_q, out_last_q;
  logic           wr_acc, commit, pop;
`ifdef FIFO_1TON_KEEP_EN
  logic [NSIZE-1:0] keep_q, keep_d, keep_merged;
  logic [NSIZE-1:0] mem_keep_q [DEPTH];
  logic [NSIZE-1:0] out_keep_q;
`endif

  always_comb begin
    wr_acc = wr_en && !wr_full;
    commit = wr_acc && (wr_last || (lane_q == LANE_MAX));
    pop    = (mem_cnt_q != '0) && (!out_vld_q || rd_en);
    merged = pack_q;
`ifdef FIFO_1TON_KEEP_EN
    keep_merged = keep_q;
`endif
    // First accepted word of a group occupies the most-significant lane.
    for (int k = 0; k < NSIZE; k++) begin
      if (lane_q == LW'(k)) begin
        merged[DSIZE*(NSIZE-1-k) +: DSIZE] = wr_data;
`ifdef FIFO_1TON_KEEP_EN
        keep_merged[NSIZE-1-k] = 1'b1;
`endif
      end
    end
    lane_d = lane_q;
    pack_d = pack_q;
`ifdef FIFO_1TON_KEEP_EN
    keep_d = keep_q;
`endif
    if (commit) begin
      lane_d = '0;
      pack_d = DEF_WIDE;
`ifdef FIFO_1TON_KEEP_EN
      keep_d = '0;
`endif
    end else if (wr_acc) begin
      lane_d = lane_q + LW'(1);
      pack_d = merged;
`ifdef FIFO_1TON_KEEP_EN
      keep_d = keep_merged;
`endif
    end
    mem_cnt_d = mem_cnt_q;
    case ({commit, pop})
      2'b10:   mem_cnt_d = mem_cnt_q + MCW'(1);
      2'b01:   mem_cnt_d = mem_cnt_q - MCW'(1);
      default: mem_cnt_d = mem_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q     <= '0;
      pack_q     <= DEF_WIDE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= DEF_WIDE;
`ifdef FIFO_1TON_KEEP_EN
      keep_q     <= '0;
      out_keep_q <= '0;
`endif
    end else begin
      lane_q    <= lane_d;
      pack_q    <= pack_d;
      mem_cnt_q <= mem_cnt_d;
`ifdef FIFO_1TON_KEEP_EN
      keep_q    <= keep_d;
`endif
      if (commit) wr_ptr_q <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PW'(1);
      // Output register is refilled only from memory, never bypassed from the pack stage.
      if (pop) begin
        rd_ptr_q   <= (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PW'(1);
        out_vld_q  <= 1'b1;
        out_data_q <= mem_data_q[rd_ptr_q];
        out_last_q <= mem_last_q[rd_ptr_q];
`ifdef FIFO_1TON_KEEP_EN
        out_keep_q <= mem_keep_q[rd_ptr_q];
`endif
      end else if (rd_en) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      mem_data_q[wr_ptr_q] <= merged;
      mem_last_q[wr_ptr_q] <= wr_last;
`ifdef FIFO_1TON_KEEP_EN
      mem_keep_q[wr_ptr_q] <= keep_merged;
`endif
    end
  end

  assign rd_data         = out_data_q;
  assign rd_vld          = out_vld_q;
  assign rd_empty        = !out_vld_q;
  assign rd_last         = out_last_q && out_vld_q;
`ifdef FIFO_1TON_KEEP_EN
  assign rd_keep         = out_vld_q ? out_keep_q : '0;
`endif
  assign rd_count        = RCW'(mem_cnt_q) + RCW'(out_vld_q);
  assign wr_count        = WCW'(rd_count) * WCW'(NSIZE) + WCW'(lane_q);
  assign wr_full         = (mem_cnt_q == MEM_FULL);
  assign wr_almost_full  = (int'(mem_cnt_q) >= DEPTH - ALMOST);
  assign rd_almost_empty = (int'(rd_count) <= ALMOST);

endmodule
